// File: rtl/cache_req_ctrl_if.sv
// cache_req_ctrl_if
//   Bundles the CPU request/response, flush, cache command/result and
//   backing-memory signals of cache_req_ctrl.
//   modport master : the controller side (drives req_ready, rsp_*, flush_done,
//                    cache_vector, cache_enable_n, mem_req/wr/addr/wdata)
//   modport slave  : the environment side (CPU, cache and memory models)
//
//   Handshakes:
//     CPU request  : a request is accepted on a rising clk edge where
//                    req_valid=1, req_ready=1 and flush_req=0; the fields are
//                    latched at that edge and never re-sampled.
//     CPU response : rsp_valid is a one-cycle strobe with no backpressure.
//     flush        : flush_req is only honoured in IDLE and must be held until
//                    flush_done (one-cycle strobe) is seen.
//     cache        : cache_enable_n=0 for exactly one cycle per command; the
//                    cache captures cache_vector at the edge ending that cycle.
//     memory       : mem_req is held with mem_wr/mem_addr/mem_wdata stable
//                    until a one-cycle mem_ack; mem_rdata is valid with mem_ack.
interface cache_req_ctrl_if #(
  parameter int TAG_WIDTH    = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 2
);
  localparam int LINE_WIDTH = TAG_WIDTH + DATA_WIDTH + OPCODE_WIDTH;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [TAG_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_hit;
  logic                  flush_req;
  logic                  flush_done;
  logic [LINE_WIDTH-1:0] cache_vector;
  logic                  cache_enable_n;
  logic [DATA_WIDTH-1:0] cache_data_in;
  logic                  cache_hit_in;
  logic                  mem_req;
  logic                  mem_wr;
  logic [TAG_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata, flush_req,
           cache_data_in, cache_hit_in, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_data, rsp_hit, flush_done,
           cache_vector, cache_enable_n, mem_req, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata, flush_req,
           cache_data_in, cache_hit_in, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_data, rsp_hit, flush_done,
           cache_vector, cache_enable_n, mem_req, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_req_ctrl.sv
// cache_req_ctrl
//   Request initiator for the tag/data cache. Accepts CPU reads/writes,
//   issues {opcode, tag, data} commands to the cache, services read misses
//   and write-through from backing memory, and issues FLASH on flush_req.
//
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     bus         : cache_req_ctrl_if.master (CPU, cache and memory signals)
//     dbg_state   : current FSM state encoding, for observation only
//   Optional (macro CACHE_REQ_CTRL_STATS_EN):
//     stat_hits[15:0], stat_misses[15:0], stat_flushes[7:0] : saturating
//     event counters, cleared by reset.
//
//   All outputs are registered and computed from the state transition, so
//   each state's outputs are visible during the cycle spent in that state.
//   Response timing, counting the cycle that starts at the acceptance edge as
//   cycle 1: read hit -> rsp_valid in cycle 3; write -> cycle 3+L; read miss
//   -> cycle 5+L, where memory asserts mem_ack L cycles after the first cycle
//   of mem_req.
module cache_req_ctrl #(
  parameter int TAG_WIDTH    = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  cache_req_ctrl_if.master     bus,
  output logic [3:0]           dbg_state
`ifdef CACHE_REQ_CTRL_STATS_EN
  ,
  output logic [15:0]          stat_hits,
  output logic [15:0]          stat_misses,
  output logic [7:0]           stat_flushes
`endif
);
  localparam int LINE_WIDTH = TAG_WIDTH + DATA_WIDTH + OPCODE_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_FLASH = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_READ  = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_WRITE = OPCODE_WIDTH'(2);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FLUSH  = 4'd1,
    S_F_DONE = 4'd2,
    S_C_RD   = 4'd3,
    S_C_CHK  = 4'd4,
    S_M_RD   = 4'd5,
    S_C_FILL = 4'd6,
    S_C_WR   = 4'd7,
    S_M_WR   = 4'd8,
    S_RESP   = 4'd9
  } state_t;

  state_t                state_q, state_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic                  flush_done_q, flush_done_d;
  logic [LINE_WIDTH-1:0] cache_vector_q, cache_vector_d;
  logic                  cache_enable_n_q, cache_enable_n_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_wr_q, mem_wr_d;
  logic [TAG_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] fill_q, fill_d;

  always_comb begin
    state_d          = state_q;
    req_ready_d      = 1'b0;
    rsp_valid_d      = 1'b0;
    rsp_data_d       = rsp_data_q;
    rsp_hit_d        = rsp_hit_q;
    flush_done_d     = 1'b0;
    cache_vector_d   = cache_vector_q;
    cache_enable_n_d = 1'b1;
    mem_req_d        = mem_req_q;
    mem_wr_d         = mem_wr_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    tag_d            = tag_q;
    wdata_d          = wdata_q;
    fill_d           = fill_q;

    case (state_q)
      S_IDLE: begin
        if (bus.flush_req) begin
          state_d          = S_FLUSH;
          cache_enable_n_d = 1'b0;
          cache_vector_d   = {OP_FLASH, {TAG_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}};
        end else if (bus.req_valid) begin
          tag_d            = bus.req_addr;
          wdata_d          = bus.req_wdata;
          cache_enable_n_d = 1'b0;
          if (bus.req_wr) begin
            state_d        = S_C_WR;
            cache_vector_d = {OP_WRITE, bus.req_addr, bus.req_wdata};
          end else begin
            state_d        = S_C_RD;
            cache_vector_d = {OP_READ, bus.req_addr, {DATA_WIDTH{1'b0}}};
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      S_FLUSH: begin
        state_d      = S_F_DONE;
        flush_done_d = 1'b1;
      end
      S_F_DONE: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      S_C_RD: begin
        // The cache captured the READ at the edge ending C_RD; its registered
        // result is visible throughout C_CHK.
        state_d = S_C_CHK;
      end
      S_C_CHK: begin
        if (bus.cache_hit_in) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = bus.cache_data_in;
          rsp_hit_d   = 1'b1;
        end else begin
          state_d     = S_M_RD;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = tag_q;
          mem_wdata_d = {DATA_WIDTH{1'b0}};
        end
      end
      S_M_RD: begin
        if (bus.mem_ack) begin
          state_d          = S_C_FILL;
          mem_req_d        = 1'b0;
          fill_d           = bus.mem_rdata;
          cache_enable_n_d = 1'b0;
          cache_vector_d   = {OP_WRITE, tag_q, bus.mem_rdata};
        end
      end
      S_C_FILL: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = fill_q;
        rsp_hit_d   = 1'b0;
      end
      S_C_WR: begin
        state_d     = S_M_WR;
        mem_req_d   = 1'b1;
        mem_wr_d    = 1'b1;
        mem_addr_d  = tag_q;
        mem_wdata_d = wdata_q;
      end
      S_M_WR: begin
        if (bus.mem_ack) begin
          state_d     = S_RESP;
          mem_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {DATA_WIDTH{1'b0}};
          rsp_hit_d   = 1'b0;
        end
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      req_ready_q      <= 1'b1;
      rsp_valid_q      <= 1'b0;
      rsp_data_q       <= '0;
      rsp_hit_q        <= 1'b0;
      flush_done_q     <= 1'b0;
      cache_vector_q   <= '0;
      cache_enable_n_q <= 1'b1;
      mem_req_q        <= 1'b0;
      mem_wr_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      tag_q            <= '0;
      wdata_q          <= '0;
      fill_q           <= '0;
    end else begin
      state_q          <= state_d;
      req_ready_q      <= req_ready_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_data_q       <= rsp_data_d;
      rsp_hit_q        <= rsp_hit_d;
      flush_done_q     <= flush_done_d;
      cache_vector_q   <= cache_vector_d;
      cache_enable_n_q <= cache_enable_n_d;
      mem_req_q        <= mem_req_d;
      mem_wr_q         <= mem_wr_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      tag_q            <= tag_d;
      wdata_q          <= wdata_d;
      fill_q           <= fill_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_hit        = rsp_hit_q;
  assign bus.flush_done     = flush_done_q;
  assign bus.cache_vector   = cache_vector_q;
  assign bus.cache_enable_n = cache_enable_n_q;
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_wr         = mem_wr_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign dbg_state          = state_q;

`ifdef CACHE_REQ_CTRL_STATS_EN
  logic        hit_evt, miss_evt, flush_evt;
  logic [15:0] stat_hits_q, stat_hits_d;
  logic [15:0] stat_misses_q, stat_misses_d;
  logic [7:0]  stat_flushes_q, stat_flushes_d;

  // Events are taken from the same decisions the FSM makes: the C_CHK
  // hit/miss sample and entry into FLUSH from IDLE.
  assign hit_evt   = (state_q == S_C_CHK) &&  bus.cache_hit_in;
  assign miss_evt  = (state_q == S_C_CHK) && !bus.cache_hit_in;
  assign flush_evt = (state_q == S_IDLE)  &&  bus.flush_req;

  always_comb begin
    stat_hits_d    = stat_hits_q;
    stat_misses_d  = stat_misses_q;
    stat_flushes_d = stat_flushes_q;
    if (hit_evt && (stat_hits_q != 16'hFFFF))
      stat_hits_d = stat_hits_q + 16'd1;
    if (miss_evt && (stat_misses_q != 16'hFFFF))
      stat_misses_d = stat_misses_q + 16'd1;
    if (flush_evt && (stat_flushes_q != 8'hFF))
      stat_flushes_d = stat_flushes_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits_q    <= '0;
      stat_misses_q  <= '0;
      stat_flushes_q <= '0;
    end else begin
      stat_hits_q    <= stat_hits_d;
      stat_misses_q  <= stat_misses_d;
      stat_flushes_q <= stat_flushes_d;
    end
  end

  assign stat_hits    = stat_hits_q;
  assign stat_misses  = stat_misses_q;
  assign stat_flushes = stat_flushes_q;
`endif
endmodule
